// File: rtl/mem_access_master_if.sv
// Bus bundle for mem_access_master.
// Groups the datapath request/response handshake and the Main_Memory port.
//   master modport : the engine (drives req_ready, rsp_*, mem_addr/wdata/strobes)
//   slave modport  : the environment (datapath requester + Main_Memory)
interface mem_access_master_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 13
);
    // Request / response handshake with the datapath
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_instr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    // Main_Memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_write;
    logic              mem_read;
    logic              mem_instruction;
    logic              mem_done;

    modport master (
        input  req_valid, req_write, req_instr, req_addr, req_wdata, mem_rdata, mem_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_addr, mem_wdata, mem_write, mem_read, mem_instruction
    );

    modport slave (
        output req_valid, req_write, req_instr, req_addr, req_wdata, mem_rdata, mem_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_addr, mem_wdata, mem_write, mem_read, mem_instruction
    );
endinterface

// File: rtl/mem_access_master.sv
// Requester-side engine for the uncached Main_Memory port.
// Accepts one load/store/fetch at a time, drives the memory strobes until mem_done or
// a timeout, then issues a one-cycle response carrying read data or an error flag.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_access_master_if.master (request/response handshake + memory port)
// Parameters: ADDR_W, DATA_W widths (must match the interface); TIMEOUT in 1..255.
module mem_access_master #(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 13,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_access_master_if.master   bus
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    // Counter value seen on the edge at which the wait reaches TIMEOUT cycles.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_error_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_write_q;
    logic              mem_read_q;
    logic              mem_instr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_instr_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // mem_done is deliberately not looked at here.
                    if (bus.req_valid && req_ready_q) begin
                        mem_addr_q  <= bus.req_addr;
                        mem_wdata_q <= bus.req_wdata;
                        mem_instr_q <= bus.req_instr;
                        mem_write_q <= bus.req_write;
                        mem_read_q  <= !bus.req_write;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    // Completion takes priority over a simultaneous timeout.
                    if (bus.mem_done) begin
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b0;
                        rsp_rdata_q <= mem_write_q ? '0 : bus.mem_rdata;
                        rsp_error_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == TimeoutLast) begin
                            mem_write_q <= 1'b0;
                            mem_read_q  <= 1'b0;
                            rsp_rdata_q <= '0;
                            rsp_error_q <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end
                    end
                end
                StResp: begin
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: begin
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rsp_rdata_q;
    assign bus.rsp_error       = rsp_error_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_instruction = mem_instr_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: table of single transactions plus
// hand-written back-to-back and reset-mid-WAIT sequences.
module tb_mem_access_master;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 13;
    localparam int unsigned TO = 15;

    logic clk;
    logic reset;

    mem_access_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_access_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple memory model: combinational read of the addressed word.
    logic [DW-1:0] mem_model [0:(1<<AW)-1];
    assign bus.mem_rdata = mem_model[bus.mem_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // delay = cycle (edge index after accept) on which mem_done is high; 0 = never (timeout)
    typedef struct {
        logic          write;
        logic          instr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned   delay;
        logic [DW-1:0] exp_rdata;
        logic          exp_error;
    } vec_t;

    vec_t vecs [10];

    // Called just after a falling edge with the engine idle; returns just after a falling edge.
    task automatic run_txn(input vec_t v);
        int unsigned n;
        chk("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = v.write;
        bus.req_instr = v.instr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        chk("mem_addr", 32'(bus.mem_addr), 32'(v.addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(v.wdata));
        n = (v.delay == 0) ? TO : v.delay;
        for (int k = 1; k <= int'(n); k++) begin
            chk("wait_mem_write", 32'(bus.mem_write), 32'(v.write));
            chk("wait_mem_read", 32'(bus.mem_read), 32'(!v.write));
            chk("wait_mem_instr", 32'(bus.mem_instruction), 32'(v.instr));
            chk("wait_ready_low", 32'(bus.req_ready), 32'd0);
            chk("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
            if (k == int'(v.delay)) begin
                bus.mem_done = 1'b1;
                if (v.write) mem_model[bus.mem_addr] = bus.mem_wdata;
            end
            @(negedge clk);
        end
        bus.mem_done = 1'b0;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
        chk("rsp_error", 32'(bus.rsp_error), 32'(v.exp_error));
        chk("resp_strobes_low", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("resp_ready_low", 32'(bus.req_ready), 32'd0);
        chk("resp_addr_held", 32'(bus.mem_addr), 32'(v.addr));
        @(negedge clk);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(bus.req_ready), 32'd1);
        chk("rdata_held", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_model[i] = '0;
        mem_model[13'h004] = 13'h0A5;
        mem_model[13'h010] = 13'h1234;

        //            write instr addr     wdata    dly exp_rdata exp_err
        vecs[0] = '{1'b0, 1'b0, 13'h004, 13'h000, 2,  13'h0A5,  1'b0};  // load
        vecs[1] = '{1'b1, 1'b0, 13'h000, 13'hF0F, 1,  13'h000,  1'b0};  // store
        vecs[2] = '{1'b0, 1'b0, 13'h000, 13'h000, 3,  13'hF0F,  1'b0};  // load back
        vecs[3] = '{1'b0, 1'b1, 13'h010, 13'h000, 1,  13'h1234, 1'b0};  // fetch
        vecs[4] = '{1'b0, 1'b0, 13'h004, 13'h000, 0,  13'h000,  1'b1};  // load timeout
        vecs[5] = '{1'b0, 1'b0, 13'h004, 13'h000, 15, 13'h0A5,  1'b0};  // done on last cycle
        vecs[6] = '{1'b1, 1'b0, 13'h1FFF, 13'h1555, 14, 13'h000, 1'b0}; // store top addr
        vecs[7] = '{1'b0, 1'b0, 13'h1FFF, 13'h000, 1, 13'h1555, 1'b0};  // load top addr
        vecs[8] = '{1'b1, 1'b0, 13'h020, 13'h0AA, 0,  13'h000,  1'b1};  // store timeout
        vecs[9] = '{1'b0, 1'b0, 13'h020, 13'h000, 1,  13'h000,  1'b0};  // unwritten word

        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_instr = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_done  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_mem_outs", 32'({bus.mem_read, bus.mem_write, bus.mem_instruction}), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Back-to-back loads with mem_done held high, including while idle.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_instr = 1'b0;
        bus.req_addr  = 13'h004;
        bus.mem_done  = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i == 7) bus.req_valid = 1'b0;
            chk("b2b_ready", 32'(bus.req_ready), 32'((i % 3 == 0) || i > 8));
            chk("b2b_read", 32'(bus.mem_read), 32'((i % 3 == 1) && i < 9));
            chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'((i % 3 == 2) && i < 9));
            if (i % 3 == 2 && i < 9) chk("b2b_rdata", 32'(bus.rsp_rdata), 32'h0A5);
            @(negedge clk);
        end
        bus.mem_done = 1'b0;

        // Reset asserted mid-WAIT on a store.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 13'h055;
        bus.req_wdata = 13'h003;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rw_write_high", 32'(bus.mem_write), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rw_strobes_async", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("rw_addr_cleared", 32'(bus.mem_addr), 32'd0);
        chk("rw_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.mem_done = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rw_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("rw_idle_ready", 32'(bus.req_ready), 32'd1);
            chk("rw_no_write", 32'(bus.mem_write), 32'd0);
            @(negedge clk);
            bus.mem_done = 1'b0;
        end
        run_txn(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_master.md
# mem_access_master

Requester-side engine for the uncached `Main_Memory` port. It accepts one load, store or instruction-fetch request at a time from the datapath over a valid/ready handshake. It drives the memory's address, data, `write`, `read` and `instruction` strobes, holds them until `Done`, then returns read data or an error through a one-cycle response. It sits between `Control` and `Main_Memory` and is the only block that drives the memory strobes.

## Interface
- `ADDR_W`, 13, address width (matches `Main_Memory`)
- `DATA_W`, 13, data word width
- `TIMEOUT`, 15, maximum cycles to wait for `mem_done` before aborting; legal range 1..255

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  engine can accept a request this cycle
- `req_write`  in  1  1 = store, 0 = load or fetch
- `req_instr`  in  1  1 = instruction fetch; forwarded to `mem_instruction`
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  store data
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_rdata`  out  DATA_W  load data; 0 for stores and errors
- `rsp_error`  out  1  qualifies `rsp_valid`; 1 = timed out
- `mem_addr`  out  ADDR_W  to `Main_Memory` address
- `mem_wdata`  out  DATA_W  to `Main_Memory` dataIn
- `mem_rdata`  in  DATA_W  from `Main_Memory` dataOut
- `mem_write`  out  1  memory write strobe
- `mem_read`  out  1  memory read strobe
- `mem_instruction`  out  1  memory instruction-space select
- `mem_done`  in  1  memory completion (`Done`)

## Operation
- **States:** IDLE, WAIT, RESP.
- **Reset values:** state = IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_error`=0, `rsp_rdata`=0. All `mem_*` outputs are 0. Timeout counter is 0.

**IDLE**
- `req_ready`=1.
- On `req_valid` && `req_ready`, register `req_addr`, `req_wdata` and `req_instr` onto `mem_addr`, `mem_wdata` and `mem_instruction`.
- Set `mem_write`=`req_write` and `mem_read`=!`req_write`.
- Clear the counter and go to WAIT.
- `mem_done` is ignored in IDLE.

**WAIT**
- `req_ready`=0.
- Strobes, address and data are held stable.
- The counter increments each cycle that `mem_done`=0.
- If `mem_done`=1:
  - Drop `mem_read` and `mem_write`.
  - For a load, latch `mem_rdata` into `rsp_rdata`; for a store, set `rsp_rdata`=0.
  - Set `rsp_error`=0 and go to RESP.
- Else if the counter reaches TIMEOUT:
  - Drop the strobes.
  - Set `rsp_rdata`=0 and `rsp_error`=1, and go to RESP.
- If `mem_done` arrives on the same edge the counter would reach TIMEOUT, `mem_done` wins: normal completion, no error.

**RESP**
- `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- `req_ready`=0 in this state.
- `rsp_rdata` and `rsp_error` hold their values until the next response.
- `mem_addr`, `mem_wdata` and `mem_instruction` hold their last values; only the strobes return to 0.
- `mem_read` and `mem_write` are never both 1.
- All outputs are registered; there is no combinational path from `req_*` or `mem_*` to any output.

## Timing
- **Accept:** the request is accepted at edge N. Strobes are high from N to the edge where `mem_done` is sampled.
- **Done path:** if `mem_done` is sampled high at edge N+k (k≥1), the strobes are low and `rsp_valid` is high after N+k. `req_ready` returns high after N+k+1.
- **Minimum occupancy:** 3 cycles from accept to next accept.
- **Timeout path:** `rsp_valid` rises after edge N+TIMEOUT with `rsp_error`=1.
- **Reset mid-operation:** asserting `reset` in any state immediately forces the reset values. Strobes drop asynchronously and no response is issued. After release, the engine is in IDLE with `req_ready`=1.
- **Back-pressure:** there is no response back-pressure. The consumer must sample `rsp_valid` every cycle.

## Test plan
- **Load:** with memory word 0x0A5 preloaded at addr 0x004, issue load at `req_addr`=0x004, `mem_done` 2 cycles after strobe. Expect `mem_read`=1 for 2 cycles, then `rsp_valid` one cycle with `rsp_rdata`=0x0A5 and `rsp_error`=0.
- **Store then load:** store 0x0F0F to addr 0 (`mem_write`=1, `mem_wdata`=0x0F0F), then load addr 0. Expect `rsp_rdata`=0x0F0F and `rsp_rdata`=0 on the store response.
- **Fetch:** fetch with `req_instr`=1 at addr 0x010. Expect `mem_instruction`=1 throughout WAIT and the correct word returned.
- **Timeout:** with `mem_done` held 0 and TIMEOUT=15, expect strobes to drop after 15 cycles, `rsp_valid`=1, `rsp_error`=1, `rsp_rdata`=0. Also drive `mem_done` on cycle 15: expect `rsp_error`=0.
- **Back-to-back / IDLE done:** hold `req_valid`=1 for 3 requests with `mem_done` immediate. Expect a 3-cycle accept spacing, `req_ready` low in WAIT and RESP, and a stray `mem_done` pulse in IDLE ignored.
- **Reset mid-WAIT:** drive `reset`=0 mid-WAIT. Expect all `mem_*` strobes 0 immediately, no `rsp_valid`, and `req_ready`=1 after release.
